// File: rtl/mac_pkg.sv
// Opcodes, FSM state type and timing constants shared by the MAC sequencer and its users.
package mac_pkg;

  localparam logic [1:0] OP_CLR = 2'b00;
  localparam logic [1:0] OP_MUL = 2'b01;
  localparam logic [1:0] OP_MAC = 2'b10;
  localparam logic [1:0] OP_SAT = 2'b11;

  localparam int MODE_BIT  = 2;
  localparam int DRAIN_CYC = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_CLR,
    ST_SAT,
    ST_DRAIN,
    ST_CAPTURE
  } seq_state_t;

  function automatic logic [2:0] mk_instr(input logic m, input logic [1:0] op);
    logic [2:0] ins;
    ins           = {1'b0, op};
    ins[MODE_BIT] = m;
    return ins;
  endfunction

endpackage

// File: rtl/mac_seq.sv
// Dot-product sequencer for the 3-stage MAC: done 4 cycles after the last accepted pair (5 with sat_en).
// Stream starvation freezes the MAC via stall; op_ready is high throughout ISSUE.
module mac_seq
  import mac_pkg::*;
#(
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             mode,
  input  logic             sat_en,
  input  logic [LEN_W-1:0] len,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [15:0]      op_a,
  input  logic [15:0]      op_b,
  output logic [2:0]       instruction,
  output logic [15:0]      multiplier,
  output logic [15:0]      multiplicand,
  output logic             stall,
  input  logic [31:0]      result,
  input  logic [7:0]       protect,
  output logic             busy,
  output logic             done,
  output logic [31:0]      dot_result,
  output logic [7:0]       dot_protect
);

  seq_state_t       state, state_nxt;
  logic             mode_q;
  logic             sat_q;
  logic             first_q;
  logic             done_q;
  logic [LEN_W-1:0] cnt_q;
  logic [1:0]       drain_q;
  logic             accept;
  logic [1:0]       flush_op;

  assign accept   = (state == ST_ISSUE) && op_valid;
  // SAT and a zero-operand MAC both leave a finished accumulator unchanged.
  assign flush_op = sat_q ? OP_SAT : OP_MAC;
  assign busy     = (state != ST_IDLE);
  assign done     = done_q;

  always_comb begin
    state_nxt    = state;
    op_ready     = 1'b0;
    stall        = 1'b1;
    instruction  = '0;
    multiplier   = '0;
    multiplicand = '0;
    case (state)
      ST_IDLE: begin
        if (start) state_nxt = (len == '0) ? ST_CLR : ST_ISSUE;
      end
      ST_ISSUE: begin
        op_ready     = 1'b1;
        stall        = !op_valid;
        instruction  = mk_instr(mode_q, first_q ? OP_MUL : OP_MAC);
        multiplier   = op_a;
        multiplicand = op_b;
        if (op_valid && (cnt_q == LEN_W'(1))) state_nxt = sat_q ? ST_SAT : ST_DRAIN;
      end
      ST_CLR: begin
        stall       = 1'b0;
        instruction = mk_instr(mode_q, OP_CLR);
        state_nxt   = ST_DRAIN;
      end
      ST_SAT: begin
        stall       = 1'b0;
        instruction = mk_instr(mode_q, OP_SAT);
        state_nxt   = ST_DRAIN;
      end
      ST_DRAIN: begin
        stall       = 1'b0;
        instruction = mk_instr(mode_q, flush_op);
        if (drain_q == 2'(DRAIN_CYC - 1)) state_nxt = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        stall       = 1'b0;
        instruction = mk_instr(mode_q, flush_op);
        state_nxt   = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_q      <= 1'b0;
      sat_q       <= 1'b0;
      first_q     <= 1'b0;
      cnt_q       <= '0;
      drain_q     <= '0;
      done_q      <= 1'b0;
      dot_result  <= '0;
      dot_protect <= '0;
    end else begin
      done_q  <= (state == ST_CAPTURE);
      drain_q <= (state == ST_DRAIN) ? drain_q + 2'd1 : 2'd0;
      if ((state == ST_IDLE) && start) begin
        mode_q  <= mode;
        sat_q   <= sat_en;
        cnt_q   <= len;
        first_q <= 1'b1;
      end
      if (accept) begin
        cnt_q   <= cnt_q - LEN_W'(1);
        first_q <= 1'b0;
      end
      // MAC output now reflects the last flush; pipeline is fully drained.
      if (state == ST_CAPTURE) begin
        dot_result  <= result;
        dot_protect <= protect;
      end
    end
  end

endmodule

// File: tb/tb_mac_seq.sv
// Bench for mac_seq with a behavioural 3-stage MAC unit and an arithmetic dot-product reference.
module tb_mac_seq;
  import mac_pkg::*;

  localparam int LEN_W = 8;
  localparam logic signed [39:0] W_MAX = 40'sh00_7FFF_FFFF;
  localparam logic signed [39:0] W_MIN = 40'shFF_8000_0000;
  localparam logic signed [19:0] L_MAX = 20'sh07FFF;
  localparam logic signed [19:0] L_MIN = 20'shF8000;

  logic             clk = 1'b0;
  logic             reset_n = 1'b1;
  logic             start = 1'b0;
  logic             mode = 1'b0;
  logic             sat_en = 1'b0;
  logic [LEN_W-1:0] len = '0;
  logic             op_valid = 1'b0;
  logic [15:0]      op_a = '0;
  logic [15:0]      op_b = '0;
  logic             op_ready, stall, busy, done;
  logic [2:0]       instruction;
  logic [15:0]      multiplier, multiplicand;
  logic [31:0]      result, dot_result;
  logic [7:0]       protect, dot_protect;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic [15:0] pa[64];
  logic [15:0] pb[64];

  mac_seq #(.LEN_W(LEN_W)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .mode(mode), .sat_en(sat_en), .len(len),
    .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
    .instruction(instruction), .multiplier(multiplier), .multiplicand(multiplicand),
    .stall(stall), .result(result), .protect(protect), .busy(busy), .done(done),
    .dot_result(dot_result), .dot_protect(dot_protect)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // MAC unit: operand register, product register, accumulator; all frozen by stall.
  logic [2:0]         s1_ins, s2_ins;
  logic [15:0]        s1_a, s1_b;
  logic signed [31:0] s2_p;
  logic signed [15:0] s2_ph, s2_pl;
  logic [39:0]        acc;
  logic               acc_md;

  function automatic logic [39:0] mac_step(input logic [39:0] a, input logic [2:0] ins,
                                           input logic signed [31:0] p,
                                           input logic signed [15:0] ph,
                                           input logic signed [15:0] pl);
    logic signed [39:0] w;
    logic signed [19:0] h, l;
    w = a;
    h = a[39:20];
    l = a[19:0];
    case (ins[1:0])
      OP_CLR: begin w = '0; h = '0; l = '0; end
      OP_MUL: begin w = 40'(p); h = 20'(ph); l = 20'(pl); end
      OP_MAC: begin w = w + 40'(p); h = h + 20'(ph); l = l + 20'(pl); end
      default: begin
        if (w > W_MAX) w = W_MAX; else if (w < W_MIN) w = W_MIN;
        if (h > L_MAX) h = L_MAX; else if (h < L_MIN) h = L_MIN;
        if (l > L_MAX) l = L_MAX; else if (l < L_MIN) l = L_MIN;
      end
    endcase
    return ins[MODE_BIT] ? {h, l} : w;
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_ins <= '0; s1_a <= '0; s1_b <= '0;
      s2_ins <= '0; s2_p <= '0; s2_ph <= '0; s2_pl <= '0;
      acc <= '0; acc_md <= 1'b0;
    end else if (!stall) begin
      s1_ins <= instruction;
      s1_a   <= multiplier;
      s1_b   <= multiplicand;
      s2_ins <= s1_ins;
      s2_p   <= $signed(s1_a) * $signed(s1_b);
      s2_ph  <= $signed(s1_a[15:8]) * $signed(s1_b[15:8]);
      s2_pl  <= $signed(s1_a[7:0]) * $signed(s1_b[7:0]);
      acc    <= mac_step(acc, s2_ins, s2_p, s2_ph, s2_pl);
      acc_md <= s2_ins[MODE_BIT];
    end
  end

  assign result  = acc_md ? {acc[35:20], acc[15:0]} : acc[31:0];
  assign protect = acc_md ? {acc[39:36], acc[19:16]} : acc[39:32];

  // Reference: plain signed sums of the pair products, then optional clamp.
  function automatic void model(input logic md, input logic st, input int n,
                                output logic [31:0] r, output logic [7:0] p);
    longint s, sh, sl;
    s = 0; sh = 0; sl = 0;
    for (int i = 0; i < n; i++) begin
      s  += longint'($signed(pa[i])) * longint'($signed(pb[i]));
      sh += longint'($signed(pa[i][15:8])) * longint'($signed(pb[i][15:8]));
      sl += longint'($signed(pa[i][7:0])) * longint'($signed(pb[i][7:0]));
    end
    if (st) begin
      if (s > 64'sd2147483647) s = 64'sd2147483647;
      if (s < -64'sd2147483648) s = -64'sd2147483648;
      if (sh > 32767) sh = 32767;
      if (sh < -32768) sh = -32768;
      if (sl > 32767) sl = 32767;
      if (sl < -32768) sl = -32768;
    end
    r = md ? {sh[15:0], sl[15:0]} : s[31:0];
    p = md ? {sh[19:16], sl[19:16]} : s[39:32];
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Runs one job from IDLE (called at a negedge); returns at the negedge where done is seen.
  task automatic run_job(input string tag, input logic md, input logic st, input int n,
                         input int gap, input logic poke, input logic use_k,
                         input logic [31:0] kr, input logic [7:0] kp);
    logic [31:0] er;
    logic [7:0]  ep;
    int s_cyc, last_acc, d_cyc, exp_span;
    model(md, st, n, er, ep);
    if (use_k) begin er = kr; ep = kp; end
    start = 1'b1; mode = md; sat_en = st; len = LEN_W'(n); s_cyc = cyc; last_acc = cyc;
    @(negedge clk);
    start = 1'b0;
    check({tag, ".busy"}, busy, 1);
    if (n == 0) begin
      check({tag, ".clr_ins"}, instruction, {md, OP_CLR});
      check({tag, ".clr_stall"}, stall, 0);
    end
    if (poke) begin
      start = 1'b1; len = 8'd3;
      @(negedge clk);
      start = 1'b0;
    end
    for (int i = 0; i < n; i++) begin
      if (i > 0) begin
        for (int g = 0; g < gap; g++) begin
          op_valid = 1'b0;
          @(negedge clk);
          check({tag, ".gap_stall"}, stall, 1);
        end
      end
      op_valid = 1'b1; op_a = pa[i]; op_b = pb[i];
      #1;
      check({tag, ".ready"}, op_ready, 1);
      check({tag, ".stall"}, stall, 0);
      check({tag, ".ins"}, instruction, {md, (i == 0) ? OP_MUL : OP_MAC});
      check({tag, ".mplr"}, {multiplier, multiplicand}, {pa[i], pb[i]});
      last_acc = cyc;
      @(negedge clk);
    end
    op_valid = 1'b0;
    d_cyc = -1;
    for (int k = 0; k < 40 && d_cyc < 0; k++) begin
      @(negedge clk);
      if (done) d_cyc = cyc;
    end
    check({tag, ".done_seen"}, d_cyc >= 0, 1);
    exp_span = (n == 0) ? 5 : n + 4 + int'(st) + gap * (n - 1);
    check({tag, ".span"}, d_cyc - s_cyc, exp_span);
    if (n > 0) check({tag, ".latency"}, d_cyc - last_acc, 4 + int'(st));
    check({tag, ".result"}, dot_result, er);
    check({tag, ".protect"}, dot_protect, ep);
    check({tag, ".busy_at_done"}, busy, 0);
  endtask

  task automatic load_t1();
    pa[0] = 16'd2;   pb[0] = 16'd3;
    pa[1] = 16'hFFFC; pb[1] = 16'd5;
    pa[2] = 16'd100; pb[2] = 16'd100;
  endtask

  initial begin
    int extra;
    #1 reset_n = 1'b0;
    #1;
    check("rst.busy", busy, 0);
    check("rst.done", done, 0);
    check("rst.dot", {dot_result, dot_protect}, 0);
    check("rst.stall", stall, 1);
    check("rst.mac_side", {instruction, multiplier, multiplicand, op_ready}, 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("idle.busy", busy, 0);

    load_t1();
    run_job("t1", 0, 0, 3, 0, 0, 1, 32'h0000_2702, 8'h00);

    pa[0] = 16'h8000; pb[0] = 16'h8000; pa[1] = 16'h8000; pb[1] = 16'h8000;
    run_job("t2s0", 0, 0, 2, 0, 0, 1, 32'h8000_0000, 8'h00);
    run_job("t2s1", 0, 1, 2, 0, 0, 1, 32'h7FFF_FFFF, 8'h00);

    for (int i = 0; i < 3; i++) begin pa[i] = 16'h7F02; pb[i] = 16'h7F03; end
    run_job("t3s0", 1, 0, 3, 0, 0, 1, 32'hBD03_0012, 8'h00);
    run_job("t3s1", 1, 1, 3, 0, 0, 1, 32'h7FFF_0012, 8'h00);

    load_t1();
    run_job("t4", 0, 0, 3, 2, 0, 1, 32'h0000_2702, 8'h00);

    // Abort a job after two of five pairs.
    start = 1'b1; mode = 1'b0; sat_en = 1'b0; len = 8'd5;
    @(negedge clk);
    start = 1'b0;
    op_valid = 1'b1; op_a = 16'd7; op_b = 16'd9;
    @(negedge clk);
    op_a = 16'd11;
    @(negedge clk);
    reset_n = 1'b0; op_valid = 1'b0;
    #1;
    check("t6.busy", busy, 0);
    check("t6.stall", stall, 1);
    check("t6.dot", {dot_result, dot_protect}, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    load_t1();
    run_job("t6.rerun", 0, 0, 3, 0, 0, 1, 32'h0000_2702, 8'h00);

    run_job("t5", 0, 0, 0, 0, 1, 1, 32'h0, 8'h00);
    extra = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (done) extra++;
    end
    check("t5.single_done", extra, 0);
    check("t5.idle", {busy, stall, instruction}, {1'b0, 1'b1, 3'b000});

    for (int j = 0; j < 12; j++) begin
      logic md, st;
      int n, g;
      md = 1'($urandom_range(0, 1));
      st = 1'($urandom_range(0, 1));
      n  = $urandom_range(1, 12);
      g  = $urandom_range(0, 2);
      for (int i = 0; i < n; i++) begin
        pa[i] = 16'($urandom);
        pb[i] = 16'($urandom);
        if (j % 4 == 0) begin
          pa[i] = md ? 16'h8080 : 16'h8000;
          pb[i] = md ? 16'h8080 : 16'h8000;
        end
      end
      run_job($sformatf("rnd%0d", j), md, st, n, g, 0, 0, '0, '0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
